// File: rtl/load_store_unit.sv
// Load/store initiator for a 64-bit-word data memory: one request at a time,
// read-modify-write for sub-word stores, sign/zero-extended loads.
module load_store_unit #(
   parameter int XLEN     = 64,
   parameter int OFF_BITS = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_data,
   output logic            resp_err,
   output logic            mem_read,
   output logic            mem_write,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] addr_p0, wdata_p0, word_p0;
   logic [2:0]      funct3_p0;
   logic            store_p0, err_p0;
   logic            accept, req_err;
   logic [XLEN-1:0] word_addr;

   function automatic logic is_err(input logic store, input logic [2:0] f3,
                                   input logic [OFF_BITS-1:0] off);
      logic illegal, mis;
      illegal = store ? f3[2] : (f3 == 3'b111);
      case (f3[1:0])
         2'b01:   mis = off[0];
         2'b10:   mis = |off[1:0];
         2'b11:   mis = |off[2:0];
         default: mis = 1'b0;
      endcase
      return illegal | mis;
   endfunction

   function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                   input logic [2:0] f3,
                                                   input logic [OFF_BITS-1:0] off);
      logic [XLEN-1:0] lane;
      lane = word >> {off, 3'b000};
      case (f3)
         3'b000:  return {{(XLEN-8){lane[7]}}, lane[7:0]};
         3'b001:  return {{(XLEN-16){lane[15]}}, lane[15:0]};
         3'b010:  return {{(XLEN-32){lane[31]}}, lane[31:0]};
         3'b100:  return {{(XLEN-8){1'b0}}, lane[7:0]};
         3'b101:  return {{(XLEN-16){1'b0}}, lane[15:0]};
         3'b110:  return {{(XLEN-32){1'b0}}, lane[31:0]};
         default: return lane;
      endcase
   endfunction

   // Full-word stores use an all-ones mask, so the stale old word drops out entirely.
   function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old,
                                                   input logic [XLEN-1:0] wdata,
                                                   input logic [1:0] size,
                                                   input logic [OFF_BITS-1:0] off);
      logic [XLEN-1:0] mask;
      case (size)
         2'b00:   mask = {{(XLEN-8){1'b0}}, 8'hFF};
         2'b01:   mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
         2'b10:   mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
         default: mask = '1;
      endcase
      return (old & ~(mask << {off, 3'b000})) | ((wdata & mask) << {off, 3'b000});
   endfunction

   assign accept    = req_valid && (state == IDLE);
   assign req_err   = is_err(req_store, req_funct3, req_addr[OFF_BITS-1:0]);
   assign word_addr = {addr_p0[XLEN-1:OFF_BITS], {OFF_BITS{1'b0}}};
   assign req_ready = rst || (state == IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_err)
                  state_nxt = RESP;
               else if (req_store && (req_funct3[1:0] == 2'b11))
                  state_nxt = WR;
               else
                  state_nxt = RD;
            end
         end
         RD:      state_nxt = store_p0 ? WR : RESP;
         WR:      state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // p0: request capture at acceptance, memory word capture in RD
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_p0   <= req_addr;
         wdata_p0  <= req_wdata;
         funct3_p0 <= req_funct3;
         store_p0  <= req_store;
         err_p0    <= req_err;
      end
      if (state == RD)
         word_p0 <= mem_rdata;
   end

   // Outputs are forced idle while rst is high so a pending write never reaches memory.
   always_comb begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_data  = '0;
      if (!rst) begin
         case (state)
            RD: begin
               mem_read = 1'b1;
               mem_addr = word_addr;
            end
            WR: begin
               mem_write = 1'b1;
               mem_addr  = word_addr;
               mem_wdata = store_merge(word_p0, wdata_p0, funct3_p0[1:0],
                                       addr_p0[OFF_BITS-1:0]);
            end
            RESP: begin
               resp_valid = 1'b1;
               resp_err   = err_p0;
               if (!err_p0 && !store_p0)
                  resp_data = load_extend(word_p0, funct3_p0, addr_p0[OFF_BITS-1:0]);
            end
            default: ;
         endcase
      end
   end

endmodule
